// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl: run/stop/clear controller for a two-digit BCD 00-99 counter.
// Debounces two raw buttons into press events and sequences IDLE/RUN/PAUSE/DONE.
// While running, it issues a count_en tick every TICK_DIV cycles. A clear press
// sends a one-cycle cnt_clr. With limit_en set, the FSM stops at the limit value.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   btn_start, btn_clear   raw active-high buttons (asynchronous to clk)
//   limit_en               1 = stop at {limit_tens,limit_ones}; 0 = free-run
//   limit_tens, limit_ones limit value (BCD; a digit > 9 never matches)
//   bcd_tens, bcd_ones     counter value feedback
//   count_en               one-cycle increment pulse to the counter
//   cnt_clr                one-cycle synchronous clear request to the counter
//   running, done          high in RUN / DONE
//   state                  IDLE=0, RUN=1, PAUSE=2, DONE=3
module counter_run_ctrl #(
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       limit_en,
    input  logic [3:0] limit_tens,
    input  logic [3:0] limit_ones,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    output logic       count_en,
    output logic       cnt_clr,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bit 0 = start button, bit 1 = clear button.
    logic [1:0]            sync1_q, sync1_d;
    logic [1:0]            sync2_q, sync2_d;
    logic [1:0]            lvl_q, lvl_d;
    logic [1:0]            press_q, press_d;
    logic [1:0][DEB_W-1:0] deb_cnt_q, deb_cnt_d;

    logic [1:0]       state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             count_en_q, count_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             running_q, running_d;
    logic             done_q, done_d;

    logic start_press_c;
    logic clr_press_c;
    logic match_c;

    // Synchronize, debounce and edge-detect both buttons.
    always_comb begin
        sync1_d   = {btn_clear, btn_start};
        sync2_d   = sync1_q;
        lvl_d     = lvl_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != lvl_q[i]) begin
                // Counting one more differing sample; accept at DEB_CYCLES.
                if (deb_cnt_q[i] == DEB_LAST) begin
                    lvl_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end
        end
        press_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            lvl_q     <= '0;
            press_q   <= '0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            lvl_q     <= lvl_d;
            press_q   <= press_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign start_press_c = press_q[0];
    assign clr_press_c   = press_q[1];

    // A limit digit above 9 can never be reached, so it disables the stop.
    assign match_c = limit_en && (limit_tens <= 4'd9) && (limit_ones <= 4'd9)
                     && (bcd_tens == limit_tens) && (bcd_ones == limit_ones);

    // Next-state, prescaler and pulse logic; clear > match > start > tick.
    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        count_en_d = 1'b0;
        cnt_clr_d  = 1'b0;
        if (clr_press_c) begin
            cnt_clr_d = 1'b1;
            state_d   = ST_IDLE;
            pre_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pre_d = '0;
                    if (start_press_c) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (match_c) begin
                        state_d = ST_DONE;
                        pre_d   = '0;
                    end else if (start_press_c) begin
                        // Prescaler holds so the interrupted interval resumes intact.
                        state_d = ST_PAUSE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d      = '0;
                        count_en_d = 1'b1;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (start_press_c) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    pre_d = '0;
                end
            endcase
        end
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            count_en_q <= 1'b0;
            cnt_clr_q  <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            count_en_q <= count_en_d;
            cnt_clr_q  <= cnt_clr_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign count_en = count_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign running  = running_q;
    assign done     = done_q;
    assign state    = state_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// tb_counter_run_ctrl: directed bench for counter_run_ctrl (TICK_DIV=4, DEB_CYCLES=2).
// A BCD counter model closes the loop through count_en/cnt_clr. A reference
// model of the controller is compared against the DUT every cycle, and
// literal expectations pin key timings.
`timescale 1ns/1ps
module tb_counter_run_ctrl;

    localparam int TD = 4;
    localparam int DB = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clear = 1'b0;
    logic       limit_en = 1'b0;
    logic [3:0] limit_tens = 4'd0;
    logic [3:0] limit_ones = 4'd0;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       count_en;
    logic       cnt_clr;
    logic       running;
    logic       done;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    int bcd_val = 0;

    // Monitor bookkeeping
    int cyc = 0;
    int run_entry = 0;
    int first_ce = -1;
    int ce_since = 0;
    int ce_cnt = 0;
    int clr_cnt = 0;
    int prev_state = 0;
    int prev_bcd = 0;
    bit seen_pause = 0;
    bit seen_done = 0;
    bit wrapped = 0;

    // Reference model state
    int m_st = 0;
    int m_pre = 0;
    int m_run [2] = '{0, 0};
    bit m_ce = 0;
    bit m_clr = 0;
    bit m_sy1 [2];
    bit m_sy2 [2];
    bit m_lvl [2];
    bit m_press [2];

    always #5 clk = ~clk;

    counter_run_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .limit_en   (limit_en),
        .limit_tens (limit_tens),
        .limit_ones (limit_ones),
        .bcd_tens   (bcd_tens),
        .bcd_ones   (bcd_ones),
        .count_en   (count_en),
        .cnt_clr    (cnt_clr),
        .running    (running),
        .done       (done),
        .state      (state)
    );

    // Two-digit BCD counter driven by the controller.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcd_val <= 0;
        else if (cnt_clr) bcd_val <= 0;
        else if (count_en) bcd_val <= (bcd_val == 99) ? 0 : bcd_val + 1;
    end
    assign bcd_tens = 4'(bcd_val / 10);
    assign bcd_ones = 4'(bcd_val % 10);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a press is seen after 2 sync samples plus DB agreeing
    // samples. The FSM reacts by rule priority, and the prescaler ticks once
    // per TD uninterrupted RUN cycles.
    initial forever begin : ref_model
        bit s_ev, c_ev, hit, nl, raw;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_st = 0; m_pre = 0; m_ce = 0; m_clr = 0;
            for (int i = 0; i < 2; i++) begin
                m_sy1[i] = 0; m_sy2[i] = 0; m_lvl[i] = 0; m_press[i] = 0; m_run[i] = 0;
            end
        end else begin
            s_ev = m_press[0];
            c_ev = m_press[1];
            hit = limit_en && (limit_tens <= 4'd9) && (limit_ones <= 4'd9)
                  && (bcd_val == int'(limit_tens) * 10 + int'(limit_ones));
            m_ce = 0;
            m_clr = 0;
            if (c_ev) begin
                m_clr = 1; m_st = 0; m_pre = 0;
            end else if (m_st == 0) begin
                m_pre = 0;
                if (s_ev) m_st = 1;
            end else if (m_st == 1) begin
                if (hit) begin
                    m_st = 3; m_pre = 0;
                end else if (s_ev) begin
                    m_st = 2;
                end else begin
                    m_pre = (m_pre + 1) % TD;
                    m_ce = (m_pre == 0);
                end
            end else if (m_st == 2) begin
                if (s_ev) m_st = 1;
            end else begin
                m_pre = 0;
            end
            for (int i = 0; i < 2; i++) begin
                raw = (i == 0) ? btn_start : btn_clear;
                nl = m_lvl[i];
                if (m_sy2[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        nl = m_sy2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_press[i] = nl && !m_lvl[i];
                m_lvl[i] = nl;
                m_sy2[i] = m_sy1[i];
                m_sy1[i] = raw;
            end
        end
    end

    // Compare process plus event bookkeeping, on the falling edge.
    initial forever begin
        @(negedge clk);
        cyc++;
        chk("count_en", int'(count_en), int'(m_ce));
        chk("cnt_clr", int'(cnt_clr), int'(m_clr));
        chk("state", int'(state), m_st);
        chk("running", int'(running), int'(m_st == 1));
        chk("done", int'(done), int'(m_st == 3));
        if (count_en && cnt_clr) chk("ce_clr_overlap", 1, 0);
        if (rst_n) begin
            if (state == 2'd1 && prev_state != 1) begin
                run_entry = cyc; first_ce = -1; ce_since = 0;
            end
            if (count_en) begin
                ce_cnt++; ce_since++;
                if (first_ce < 0) first_ce = cyc;
            end
            if (cnt_clr) clr_cnt++;
            if (state == 2'd2) seen_pause = 1;
            if (state == 2'd3) seen_done = 1;
            if (prev_bcd == 99 && bcd_val == 0) wrapped = 1;
        end
        prev_state = int'(state);
        prev_bcd = bcd_val;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press(input bit s, input bit c, input int hold);
        btn_start = s;
        btn_clear = c;
        repeat (hold) step();
        btn_start = 0;
        btn_clear = 0;
    endtask

    task automatic wait_state(input string nm, input int s, input int lim);
        int n = 0;
        while (int'(state) != s && n < lim) begin
            step();
            n++;
        end
        chk(nm, int'(state), s);
    endtask

    initial begin
        int n;
        repeat (3) step();
        chk("rst_state", int'(state), 0);
        chk("rst_count_en", int'(count_en), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_done", int'(done), 0);
        rst_n = 1;
        repeat (3) step();

        // Bounce shorter than the debounce window
        ce_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            btn_start = 1; step();
            btn_start = 0; step();
        end
        repeat (8) step();
        chk("bounce_state", int'(state), 0);
        chk("bounce_ce", ce_cnt, 0);

        // Clean start press: IDLE -> RUN, ticks every TD cycles
        press(1, 0, 6);
        n = 0;
        while (cyc != run_entry + 19 && n < 60) begin step(); n++; end
        chk("run_state", int'(state), 1);
        chk("first_ce_delay", first_ce - run_entry, 4);
        chk("ce_in_19_cycles", ce_since, 4);

        // Pause, hold 10 cycles, resume
        press(1, 0, 4);
        wait_state("enter_pause", 2, 20);
        ce_cnt = 0;
        repeat (10) step();
        chk("pause_ce", ce_cnt, 0);
        chk("pause_state", int'(state), 2);
        press(1, 0, 4);
        wait_state("resume", 1, 20);
        repeat (12) step();

        // Clear from RUN
        clr_cnt = 0;
        press(0, 1, 4);
        wait_state("clear_to_idle", 0, 20);
        repeat (6) step();
        chk("clear_pulses", clr_cnt, 1);
        chk("clear_bcd", bcd_val, 0);

        // Limit already matched on entry: immediate DONE, no ticks
        limit_en = 1; limit_tens = 4'd0; limit_ones = 4'd0;
        ce_cnt = 0;
        press(1, 0, 4);
        wait_state("limit00_done", 3, 20);
        chk("limit00_ce", ce_cnt, 0);
        press(0, 1, 4);
        wait_state("limit00_clear", 0, 20);
        repeat (6) step();

        // Limit 03: three ticks then DONE; start ignored, clear exits
        limit_tens = 4'd0; limit_ones = 4'd3;
        ce_cnt = 0;
        press(1, 0, 4);
        wait_state("limit03_done", 3, 60);
        chk("limit03_ce", ce_cnt, 3);
        chk("limit03_bcd", bcd_val, 3);
        chk("limit03_done_out", int'(done), 1);
        press(1, 0, 4);
        repeat (8) step();
        chk("done_ignores_start", int'(state), 3);
        limit_en = 0;
        repeat (3) step();
        chk("done_limit_en_drop", int'(state), 3);
        clr_cnt = 0;
        press(0, 1, 4);
        wait_state("done_clear", 0, 20);
        repeat (6) step();
        chk("done_clear_pulses", clr_cnt, 1);

        // Non-BCD limit: free-run through 99 -> 00
        limit_en = 1; limit_tens = 4'hA; limit_ones = 4'd0;
        seen_done = 0; wrapped = 0;
        press(1, 0, 4);
        repeat (430) step();
        chk("wrap_never_done", int'(seen_done), 0);
        chk("wrap_seen", int'(wrapped), 1);
        chk("wrap_running", int'(state), 1);

        // Start and clear together in RUN behave as clear
        clr_cnt = 0; seen_pause = 0;
        press(1, 1, 4);
        wait_state("both_to_idle", 0, 20);
        repeat (6) step();
        chk("both_clr_pulses", clr_cnt, 1);
        chk("both_no_pause", int'(seen_pause), 0);

        // Reset mid-RUN clears outputs immediately
        press(1, 0, 4);
        wait_state("rerun", 1, 20);
        repeat (6) step();
        #2 rst_n = 0;
        #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_count_en", int'(count_en), 0);
        chk("midrst_cnt_clr", int'(cnt_clr), 0);
        chk("midrst_running", int'(running), 0);
        chk("midrst_done", int'(done), 0);
        step();
        rst_n = 1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
Run/stop/clear controller for the two-digit BCD 00–99 counter. It converts raw push-button levels into debounced press events and sequences a 4-state FSM. It generates the one-cycle `count_en` tick from a clock prescaler and issues a one-cycle clear request to the counter. It monitors the counter's BCD outputs to stop at an optional programmable limit.

Parameters:
TICK_DIV, 50000000, clk cycles per count_en tick (≥2)
DEB_CYCLES, 1000000, consecutive stable synchronized samples needed to accept a button level change (≥1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_start  input  1  raw start/stop button, active-high, asynchronous to clk
btn_clear  input  1  raw clear button, active-high, asynchronous to clk
limit_en  input  1  1 = stop at limit value; 0 = free-run with 99→00 wrap
limit_tens  input  4  limit tens digit (BCD)
limit_ones  input  4  limit ones digit (BCD)
bcd_tens  input  4  counter tens digit feedback
bcd_ones  input  4  counter ones digit feedback
count_en  output  1  one-cycle increment pulse to the counter
cnt_clr  output  1  one-cycle synchronous clear request to the counter
running  output  1  high in RUN
done  output  1  high in DONE
state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Synchronizers, debounce counters, debounced levels and prescaler are all cleared to 0.
- Button path, per button:
  - 2-flop synchronizer.
  - Debounce counter: increments while the synchronized level differs from the debounced level; resets to 0 when they match. When it reaches DEB_CYCLES, the debounced level takes the new value and the counter resets.
  - Press pulse: one cycle, asserted the cycle after the debounced level rises 0→1. Releases generate no event.
- Prescaler:
  - Range 0..TICK_DIV-1. It counts only in RUN.
  - At TICK_DIV-1 it wraps to 0 and count_en (registered) is high for exactly one cycle.
  - Held at its value in PAUSE.
  - Forced to 0 in IDLE and DONE, and on any clear.
  - First count_en after IDLE→RUN occurs TICK_DIV cycles after the RUN entry cycle.
- Limit match (combinational compare):
  - Match = limit_en AND {bcd_tens,bcd_ones} == {limit_tens,limit_ones} AND both limit digits ≤9.
  - Non-BCD limit digits (>9) never match.
- FSM (registered; an event on cycle N changes state at the end of N):
  - IDLE:
    - clear press → cnt_clr pulse, stay IDLE.
    - start press → RUN.
  - RUN:
    - clear press → cnt_clr, IDLE.
    - else match → DONE, and no count_en is issued that cycle.
    - else start press → PAUSE.
    - else tick → count_en.
  - PAUSE:
    - clear press → cnt_clr, IDLE.
    - start press → RUN; the prescaler resumes from its held value.
  - DONE:
    - clear press → cnt_clr, IDLE.
    - start presses ignored.
- Priority: clear > limit match > start > tick. Simultaneous start+clear presses behave as clear only.
- count_en and cnt_clr are never high in the same cycle. count_en is never high outside RUN.
- Match already true on RUN entry (e.g. limit 00 after clear) → DONE on the next cycle, with zero count_en pulses.
- limit_en=0: the counter free-runs and wraps 99→00 with no state change.
- limit_en dropping in DONE does not leave DONE; only clear exits.
- Reset asserted mid-RUN: everything returns to reset values immediately. No count_en or cnt_clr glitch.

Test Plan:
- TICK_DIV=4, DEB_CYCLES=2; hold btn_start high for 6 cycles, then release → exactly one press, state IDLE→RUN. count_en pulses every 4th cycle, first at 4 cycles after RUN entry.
- Bounce btn_start 1-cycle high/low ×5 (shorter than DEB_CYCLES) → no press, state stays IDLE, no count_en.
- In RUN, press start, wait 10 cycles, press start again → PAUSE with no count_en pulses during the pause. On resume, next count_en arrives after the remaining prescaler cycles, so the total interval excluding the pause is 4.
- limit_en=1, limit=0x03, counter model fed by count_en → exactly 3 count_en pulses. When bcd reaches 03, state=DONE, done=1. A start press is ignored; a clear press gives cnt_clr for one cycle and state=IDLE.
- limit_en=1, limit_tens=0xA → free-run through 99→00 wrap, never DONE.
- Start and clear pressed on the same cycle in RUN → cnt_clr=1, state=IDLE, no PAUSE. Reset asserted mid-RUN → all outputs 0 the same cycle.
